// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// ----------------------------------------------------------------------------
// A simple AXI3-style burst slave in front of a single-port block RAM. It
// handles one transaction at a time. Addresses are word addresses, and every
// burst is INCR-like: beat n goes to RAM[(addr + n) mod 2^DEPTH_LOG2].
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   AW* (VALID/READY/ID/LEN/ADDR)  : write address channel
//   W*  (VALID/READY/LAST/ID/DATA) : write data channel
//   B*  (VALID/READY/ID)           : write response channel
//   AR* (VALID/READY/ID/LEN/ADDR)  : read address channel
//   R*  (VALID/READY/LAST/ID/DATA) : read data channel
//   err                           : sticky protocol-error flag (WLAST/WID misuse)
// ----------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            AWID,
  input  logic [3:0]            AWLEN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic                  WLAST,
  input  logic [3:0]            WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [3:0]            BID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [3:0]            ARID,
  input  logic [3:0]            ARLEN,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  RLAST,
  output logic [3:0]            RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_DATA} state_t;

  localparam logic SERVED_READ  = 1'b0;
  localparam logic SERVED_WRITE = 1'b1;

  state_t                  state_q, state_d;
  logic [3:0]              id_q, id_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [3:0]              len_q, len_d;
  logic [3:0]              beat_q, beat_d;
  logic                    last_served_q, last_served_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   ram_idx;
  logic                    ram_we;
  logic                    ram_re;
  logic                    wr_pick;

  // Only the low DEPTH_LOG2 address bits index the RAM; the rest alias.
  generate
    if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^{AWADDR[ADDR_WIDTH-1:DEPTH_LOG2], ARADDR[ADDR_WIDTH-1:DEPTH_LOG2]};
    end
  endgenerate

  // The natural overflow of this add gives the wrap to index 0.
  assign ram_idx = addr_q + DEPTH_LOG2'(beat_q);

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    last_served_d = last_served_q;
    err_d         = err_q;
    AWREADY       = 1'b0;
    ARREADY       = 1'b0;
    WREADY        = 1'b0;
    BVALID        = 1'b0;
    RVALID        = 1'b0;
    RLAST         = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;

    // Write is picked when it is the only request, or when both are pending
    // and the read was served last. Otherwise the read side owns the ready,
    // so exactly one of AWREADY/ARREADY is high while idle.
    wr_pick = AWVALID && (!ARVALID || (last_served_q == SERVED_READ));

    unique case (state_q)
      IDLE: begin
        AWREADY = !rst && wr_pick;
        ARREADY = !rst && !wr_pick;
        if (AWVALID && AWREADY) begin
          id_d          = AWID;
          addr_d        = AWADDR[DEPTH_LOG2-1:0];
          len_d         = AWLEN;
          beat_d        = 4'd0;
          last_served_d = SERVED_WRITE;
          state_d       = WR_DATA;
        end else if (ARVALID && ARREADY) begin
          id_d          = ARID;
          addr_d        = ARADDR[DEPTH_LOG2-1:0];
          len_d         = ARLEN;
          beat_d        = 4'd0;
          last_served_d = SERVED_READ;
          state_d       = RD_ISSUE;
        end
      end
      WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          ram_we = 1'b1;
          // Burst length comes from AWLEN; WLAST/WID are only checked.
          if ((WLAST != (beat_q == len_q)) || (WID != id_q)) begin
            err_d = 1'b1;
          end
          if (beat_q == len_q) begin
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      WR_RESP: begin
        BVALID = 1'b1;
        if (BREADY) begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        ram_re  = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        RVALID = 1'b1;
        RLAST  = (beat_q == len_q);
        if (RREADY) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 4'd1;
            state_d = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      id_q          <= 4'd0;
      addr_q        <= '0;
      len_q         <= 4'd0;
      beat_q        <= 4'd0;
      last_served_q <= SERVED_READ;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      last_served_q <= last_served_d;
      err_q         <= err_d;
    end
  end

  // RAM array is never reset; a beat arriving on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      mem[ram_idx] <= WDATA;
    end
  end

  // Registered read port. It only loads in RD_ISSUE, so RDATA holds while
  // RD_DATA is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ram_re) begin
      rdata_q <= mem[ram_idx];
    end
  end

  assign BID   = id_q;
  assign RID   = id_q;
  assign RDATA = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed testbench for axi_sram_slave (default parameters).
module tb_axi_sram_slave;

  localparam int AW = 26;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          AWVALID, AWREADY;
  logic [3:0]    AWID, AWLEN;
  logic [AW-1:0] AWADDR;
  logic          WVALID, WREADY, WLAST;
  logic [3:0]    WID;
  logic [DW-1:0] WDATA;
  logic          BVALID, BREADY;
  logic [3:0]    BID;
  logic          ARVALID, ARREADY;
  logic [3:0]    ARID, ARLEN;
  logic [AW-1:0] ARADDR;
  logic          RVALID, RREADY, RLAST;
  logic [3:0]    RID;
  logic [DW-1:0] RDATA;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(14)) dut (
    .clk(clk), .rst(rst),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
    .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data + response phase of a write; entered right after the AW handshake.
  task automatic w_phase(input logic [3:0] id, input logic [3:0] len,
                         input logic [31:0] base, input logic [3:0] last_at);
    for (int b = 0; b <= int'(len); b++) begin
      WVALID = 1'b1;
      WID    = id;
      WDATA  = base + 32'(b);
      WLAST  = (b == int'(last_at));
      #1;
      chk("wready", 32'(WREADY), 32'd1);
      step();
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    #1;
    chk("bvalid", 32'(BVALID), 32'd1);
    chk("bid", 32'(BID), 32'(id));
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    #1;
    chk("bvalid_clr", 32'(BVALID), 32'd0);
    $display("write id=%0d len=%0d base=0x%0h done, err=%0d", id, len, base, err);
  endtask

  // Read data phase; entered right after the AR handshake edge.
  task automatic r_phase(input logic [3:0] id, input logic [3:0] len, input logic [31:0] base);
    chk("rvalid_issue", 32'(RVALID), 32'd0);
    step();
    for (int b = 0; b <= int'(len); b++) begin
      chk("rvalid", 32'(RVALID), 32'd1);
      chk("rid", 32'(RID), 32'(id));
      chk("rlast", 32'(RLAST), (b == int'(len)) ? 32'd1 : 32'd0);
      chk("rdata", RDATA, base + 32'(b));
      RREADY = 1'b1;
      step();
      RREADY = 1'b0;
      chk("rvalid_gap", 32'(RVALID), 32'd0);
      if (b < int'(len)) step();
    end
    $display("read id=%0d len=%0d base=0x%0h done", id, len, base);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [AW-1:0] addr, input logic [3:0] len,
                          input logic [31:0] base, input logic [3:0] last_at);
    AWVALID = 1'b1; AWID = id; AWLEN = len; AWADDR = addr;
    #1;
    chk("awready", 32'(AWREADY), 32'd1);
    step();
    AWVALID = 1'b0;
    w_phase(id, len, base, last_at);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [AW-1:0] addr, input logic [3:0] len,
                         input logic [31:0] base);
    ARVALID = 1'b1; ARID = id; ARLEN = len; ARADDR = addr;
    #1;
    chk("arready", 32'(ARREADY), 32'd1);
    chk("awready_off", 32'(AWREADY), 32'd0);
    step();
    ARVALID = 1'b0;
    r_phase(id, len, base);
  endtask

  initial begin
    rst = 1'b1;
    AWVALID = 0; AWID = 0; AWLEN = 0; AWADDR = '0;
    WVALID = 0; WLAST = 0; WID = 0; WDATA = '0; BREADY = 0;
    ARVALID = 0; ARID = 0; ARLEN = 0; ARADDR = '0; RREADY = 0;

    // Reset state
    step(); step();
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_wready", 32'(WREADY), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rlast", 32'(RLAST), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bid", 32'(BID), 32'd0);
    chk("rst_rid", 32'(RID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_arready", 32'(ARREADY), 32'd1);
    $display("reset checked");

    // Arbitration: both requests held, expect W, R, W, R
    AWVALID = 1; AWID = 4'd1; AWLEN = 4'd0; AWADDR = 26'h20;
    ARVALID = 1; ARID = 4'd2; ARLEN = 4'd0; ARADDR = 26'h20;
    #1;
    chk("arb1_w_aw", 32'(AWREADY), 32'd1);
    chk("arb1_w_ar", 32'(ARREADY), 32'd0);
    step();
    w_phase(4'd1, 4'd0, 32'h11, 4'd0);
    chk("arb2_r_ar", 32'(ARREADY), 32'd1);
    chk("arb2_r_aw", 32'(AWREADY), 32'd0);
    step();
    r_phase(4'd2, 4'd0, 32'h11);
    #1;
    chk("arb3_w_aw", 32'(AWREADY), 32'd1);
    chk("arb3_w_ar", 32'(ARREADY), 32'd0);
    step();
    w_phase(4'd1, 4'd0, 32'h22, 4'd0);
    chk("arb4_r_ar", 32'(ARREADY), 32'd1);
    chk("arb4_r_aw", 32'(AWREADY), 32'd0);
    step();
    AWVALID = 0; ARVALID = 0;
    r_phase(4'd2, 4'd0, 32'h22);
    $display("arbitration W,R,W,R checked");

    // Basic burst write then read back
    do_write(4'd3, 26'h10, 4'd3, 32'hA0, 4'd3);
    chk("err_clean", 32'(err), 32'd0);
    do_read(4'd5, 26'h10, 4'd3, 32'hA0);

    // Wrap at the top of the RAM
    do_write(4'd4, 26'h3FFF, 4'd1, 32'hB0, 4'd1);
    do_read(4'd4, 26'h3FFF, 4'd1, 32'hB0);
    do_read(4'd4, 26'h0, 4'd0, 32'hB1);

    // Early WLAST: error flagged, burst still completes
    do_write(4'd7, 26'h40, 4'd3, 32'hD0, 4'd1);
    chk("err_set", 32'(err), 32'd1);
    do_read(4'd7, 26'h40, 4'd3, 32'hD0);
    chk("err_sticky", 32'(err), 32'd1);

    // Stall in RD_DATA, then reset during it
    ARVALID = 1; ARID = 4'd9; ARLEN = 4'd3; ARADDR = 26'h10;
    #1;
    chk("stall_arready", 32'(ARREADY), 32'd1);
    step();
    ARVALID = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_rvalid", 32'(RVALID), 32'd1);
      chk("stall_rdata", RDATA, 32'hA0);
      step();
    end
    rst = 1'b1;
    step();
    chk("rrst_rvalid", 32'(RVALID), 32'd0);
    chk("rrst_rdata", RDATA, 32'd0);
    chk("rrst_err", 32'(err), 32'd0);
    chk("rrst_rid", 32'(RID), 32'd0);
    rst = 1'b0;
    #1;
    chk("rrst_arready", 32'(ARREADY), 32'd1);
    $display("stall + reset in RD_DATA checked");
    do_read(4'd9, 26'h10, 4'd3, 32'hA0);

    // Reset mid write burst: no response, committed beats retained
    AWVALID = 1; AWID = 4'd2; AWLEN = 4'd3; AWADDR = 26'h60;
    #1;
    chk("mw_awready", 32'(AWREADY), 32'd1);
    step();
    AWVALID = 0;
    for (int b = 0; b < 2; b++) begin
      WVALID = 1; WID = 4'd2; WDATA = 32'hC0 + 32'(b); WLAST = 0;
      step();
    end
    WVALID = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mw_bvalid", 32'(BVALID), 32'd0);
    chk("mw_wready", 32'(WREADY), 32'd0);
    $display("reset mid write burst checked");
    do_read(4'd2, 26'h60, 4'd1, 32'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
